// File: rtl/gf7_mul_arbiter.sv
// gf7_mul_arbiter: round-robin front end for one shared combinational
// GF(2^7) multiplier (p(x) = x^7 + x + 1). At most one requester is granted
// per cycle. Its operands are steered to the multiplier, and the product is
// captured in a single-entry output slot tagged with the requester id. A
// counter tracks completed response handshakes.
module gf7_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_valid_i,
   output logic [NREQ-1:0]   req_ready_o,
   input  logic [7*NREQ-1:0] req_a_i,
   input  logic [7*NREQ-1:0] req_b_i,
   output logic [6:0]        mul_a_o,
   output logic [6:0]        mul_b_o,
   input  logic [6:0]        mul_p_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [6:0]        rsp_data_o,
   output logic [IDW-1:0]    rsp_id_o,
   output logic [CNTW-1:0]   op_count_o
);

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

   slot_e           state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [6:0]      data_q, data_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  sel_idx;
   logic            grant_valid;
   logic            slot_free;
   logic            rsp_fire;

   assign rsp_valid_o = (state_q == SLOT_FULL);
   assign slot_free   = !rsp_valid_o || rsp_ready_i;
   assign rsp_fire    = rsp_valid_o && rsp_ready_i;
   assign rsp_data_o  = data_q;
   assign rsp_id_o    = id_q;
   assign op_count_o  = count_q;

   // Round-robin search: ptr..NREQ-1 first, then 0..ptr-1. The grant is
   // suppressed while the slot cannot take a product or reset is asserted.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_valid && (i >= int'(ptr_q)) && req_valid_i[i]) begin
            grant_valid = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_valid && (i < int'(ptr_q)) && req_valid_i[i]) begin
            grant_valid = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
      if (rst_i || !slot_free) begin
         grant_valid = 1'b0;
         grant_idx   = '0;
      end
   end

   // One-hot ready back to the winning requester, and the operand mux.
   // With no grant the mux follows ptr so the multiplier never sees X.
   always_comb begin
      req_ready_o = '0;
      mul_a_o     = '0;
      mul_b_o     = '0;
      sel_idx     = grant_valid ? grant_idx : ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_valid && (grant_idx == IDW'(i))) begin
            req_ready_o[i] = 1'b1;
         end
         if (sel_idx == IDW'(i)) begin
            mul_a_o = req_a_i[7*i +: 7];
            mul_b_o = req_b_i[7*i +: 7];
         end
      end
   end

   // Output slot FSM, pointer advance, result capture and handshake counter.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      id_d    = id_q;
      count_d = count_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (grant_valid) begin
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (rsp_ready_i && !grant_valid) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
      if (grant_valid) begin
         data_d = mul_p_i;
         id_d   = grant_idx;
         ptr_d  = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + IDW'(1);
      end
      if (rsp_fire) begin
         count_d = count_q + CNTW'(1);
      end
   end

   // State registers; reset drops any pending result without counting it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SLOT_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         id_q    <= id_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_gf7_mul_arbiter.sv
// tb_gf7_mul_arbiter: bench for gf7_mul_arbiter. Provides the shared GF(2^7)
// multiplier, keeps a reference arbiter model with a scoreboard queue of
// expected responses, and runs table vectors plus multi-cycle corner cases.
module tb_gf7_mul_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 16;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   reqValid;
   logic [NREQ-1:0]   reqReady;
   logic [7*NREQ-1:0] reqA;
   logic [7*NREQ-1:0] reqB;
   logic [6:0]        mulA;
   logic [6:0]        mulB;
   logic [6:0]        mulP;
   logic              rspValid;
   logic              rspReady;
   logic [6:0]        rspData;
   logic [IDW-1:0]    rspId;
   logic [CNTW-1:0]   opCount;

   typedef struct {
      logic [6:0]     data;
      logic [IDW-1:0] id;
   } rsp_t;

   typedef struct {
      int         idx;
      logic [6:0] a;
      logic [6:0] b;
      logic [6:0] expP;
   } vec_t;

   rsp_t            sbQ[$];
   int              mPtr;
   int              mLastGrant;
   logic [CNTW-1:0] mCount;
   int              checks;
   int              errors;

   gf7_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (reqValid),
      .req_ready_o (reqReady),
      .req_a_i     (reqA),
      .req_b_i     (reqB),
      .mul_a_o     (mulA),
      .mul_b_o     (mulB),
      .mul_p_i     (mulP),
      .rsp_valid_o (rspValid),
      .rsp_ready_i (rspReady),
      .rsp_data_o  (rspData),
      .rsp_id_o    (rspId),
      .op_count_o  (opCount)
   );

   // Shift-and-add multiply in GF(2^7), reducing x^7 to x + 1.
   function automatic logic [6:0] gfMul(input logic [6:0] a, input logic [6:0] b);
      logic [6:0] r;
      logic [6:0] t;
      r = '0;
      t = a;
      for (int i = 0; i < 7; i++) begin
         if (b[i]) r = r ^ t;
         t = t[6] ? ({t[5:0], 1'b0} ^ 7'h03) : {t[5:0], 1'b0};
      end
      return r;
   endfunction

   assign mulP = gfMul(mulA, mulB);

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one clock cycle with the inputs already driven. Compares the DUT
   // against the reference model, then advances the model past the edge.
   task automatic applyStimulus(input bit doCheck);
      bit   slotFree;
      int   g;
      int   j;
      logic [NREQ-1:0] expReady;
      rsp_t item;
      #1;
      slotFree = (sbQ.size() == 0) || rspReady;
      g = -1;
      if (!rst && slotFree) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (mPtr + k) % NREQ;
            if (g < 0 && reqValid[j]) g = j;
         end
      end
      expReady = (g >= 0) ? NREQ'(1 << g) : '0;
      if (doCheck) begin
         checkOutput("req_ready", 32'(reqReady), 32'(expReady));
         checkOutput("rsp_valid", 32'(rspValid), 32'(sbQ.size() != 0));
         checkOutput("op_count", 32'(opCount), 32'(mCount));
         if (sbQ.size() != 0) begin
            checkOutput("rsp_data", 32'(rspData), 32'(sbQ[0].data));
            checkOutput("rsp_id", 32'(rspId), 32'(sbQ[0].id));
         end
         j = (g >= 0) ? g : mPtr;
         checkOutput("mul_a", 32'(mulA), 32'(reqA[7*j +: 7]));
         checkOutput("mul_b", 32'(mulB), 32'(reqB[7*j +: 7]));
      end
      mLastGrant = g;
      if (rst) begin
         sbQ.delete();
         mCount = '0;
         mPtr   = 0;
      end else begin
         if (sbQ.size() != 0 && rspReady) begin
            void'(sbQ.pop_front());
            mCount = mCount + 1'b1;
         end
         if (g >= 0) begin
            item.data = gfMul(reqA[7*g +: 7], reqB[7*g +: 7]);
            item.id   = IDW'(g);
            sbQ.push_back(item);
            mPtr = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b1);
      rst = 1'b0;
      checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset_rsp_data", 32'(rspData), 32'd0);
      checkOutput("reset_rsp_id", 32'(rspId), 32'd0);
      checkOutput("reset_op_count", 32'(opCount), 32'd0);
   endtask

   task automatic randomOperands();
      for (int i = 0; i < NREQ; i++) begin
         reqA[7*i +: 7] = 7'($urandom_range(0, 127));
         reqB[7*i +: 7] = 7'($urandom_range(0, 127));
      end
   endtask

   // Main test sequence.
   initial begin
      vec_t vecs[5];
      int   guard;
      checks     = 0;
      errors     = 0;
      mPtr       = 0;
      mLastGrant = -1;
      mCount     = '0;
      rst        = 1'b1;
      reqValid   = '0;
      reqA       = '0;
      reqB       = '0;
      rspReady   = 1'b0;

      vecs[0] = '{idx: 0, a: 7'h02, b: 7'h40, expP: 7'h03};
      vecs[1] = '{idx: 2, a: 7'h40, b: 7'h40, expP: 7'h60};
      vecs[2] = '{idx: 2, a: 7'h7F, b: 7'h01, expP: 7'h7F};
      vecs[3] = '{idx: 2, a: 7'h00, b: 7'h55, expP: 7'h00};
      vecs[4] = '{idx: 2, a: 7'h03, b: 7'h03, expP: 7'h05};

      @(negedge clk);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      doReset();

      // Single-product vectors, one at a time with rsp_ready held high.
      $display("[TB] table vectors");
      rspReady = 1'b1;
      for (int v = 0; v < 5; v++) begin
         reqValid = NREQ'(1 << vecs[v].idx);
         reqA[7*vecs[v].idx +: 7] = vecs[v].a;
         reqB[7*vecs[v].idx +: 7] = vecs[v].b;
         applyStimulus(1'b1);
         reqValid = '0;
         checkOutput("vec_rsp_valid", 32'(rspValid), 32'd1);
         checkOutput("vec_rsp_data", 32'(rspData), 32'(vecs[v].expP));
         checkOutput("vec_rsp_id", 32'(rspId), 32'(vecs[v].idx));
         applyStimulus(1'b1);
         checkOutput("vec_op_count", 32'(opCount), 32'(v + 1));
      end

      // All requesters valid: strict rotation, one result per cycle.
      $display("[TB] full rotation");
      doReset();
      randomOperands();
      reqValid = '1;
      rspReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1);
         checkOutput("rot_rsp_id", 32'(rspId), 32'(k % NREQ));
      end
      reqValid = '0;
      applyStimulus(1'b1);
      checkOutput("rot_op_count", 32'(opCount), 32'd8);

      // Back-pressure with req1 and req3 pending.
      $display("[TB] back-pressure");
      doReset();
      randomOperands();
      reqValid = 4'b1010;
      rspReady = 1'b0;
      applyStimulus(1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
         checkOutput("bp_rsp_data", 32'(rspData), 32'(gfMul(reqA[7 +: 7], reqB[7 +: 7])));
         checkOutput("bp_rsp_id", 32'(rspId), 32'd1);
         applyStimulus(1'b1);
      end
      rspReady = 1'b1;
      #1;
      checkOutput("bp_release_grant", 32'(reqReady), 32'b1000);
      applyStimulus(1'b1);
      checkOutput("bp_release_id", 32'(rspId), 32'd3);
      checkOutput("bp_release_count", 32'(opCount), 32'd1);

      // Reset while a result is pending and requests are still valid.
      $display("[TB] mid-operation reset");
      rspReady = 1'b0;
      applyStimulus(1'b1);
      checkOutput("mid_rsp_valid_before", 32'(rspValid), 32'd1);
      doReset();
      reqValid = 4'b0110;
      rspReady = 1'b1;
      #1;
      checkOutput("post_reset_grant", 32'(reqReady), 32'b0010);
      applyStimulus(1'b1);
      checkOutput("post_reset_id", 32'(rspId), 32'd1);

      // Randomised traffic; operands only change when the requester is free to.
      $display("[TB] random traffic");
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!reqValid[i] || mLastGrant == i) begin
               reqValid[i] = 1'($urandom_range(0, 1));
               reqA[7*i +: 7] = 7'($urandom_range(0, 127));
               reqB[7*i +: 7] = 7'($urandom_range(0, 127));
            end
         end
         rspReady = ($urandom_range(0, 3) != 0);
         applyStimulus(1'b1);
      end

      // Counter wrap: drive up to 0xFFFE, then three more completions.
      $display("[TB] counter wrap");
      doReset();
      reqValid = '1;
      rspReady = 1'b1;
      guard = 0;
      while (mCount != 16'hFFFE && guard < 70000) begin
         applyStimulus(1'b0);
         guard++;
      end
      checkOutput("wrap_preload_reached", 32'(guard < 70000), 32'd1);
      checkOutput("wrap_preload_count", 32'(opCount), 32'hFFFE);
      applyStimulus(1'b1);
      checkOutput("wrap_count_1", 32'(opCount), 32'hFFFF);
      applyStimulus(1'b1);
      checkOutput("wrap_count_2", 32'(opCount), 32'h0000);
      applyStimulus(1'b1);
      checkOutput("wrap_count_3", 32'(opCount), 32'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
